poly_mix_pwm: RTL and testbench
===============================

# poly_mix_pwm

Parametrised successor to the fixed 12-voice signal mixer plus PWM output stage of the synthesizer top level. It captures `CHANNELS` voice samples on each sample-rate strobe and sums only the enabled voices. It divides the sum by the number of enabled voices, so loudness does not scale with voice count, and drives a `WIDTH`-bit PWM audio output. The block sits between the waveshaper bank and the audio pin, and replaces the combinational mixer and separate PWM stage.

## Interface
- `CHANNELS`, default 12: number of voice inputs, 1..32.
- `WIDTH`, default 8: unsigned sample width, and PWM counter width.
- Derived: `SUMW = WIDTH + $clog2(CHANNELS)`, `CW = $clog2(CHANNELS+1)`.
- `clk`  input  1: system clock.
- `n_rst`  input  1: asynchronous, active-low reset.
- `start`  input  1: sample-rate strobe, one-cycle pulse.
- `samples`  input  `CHANNELS*WIDTH`: packed unsigned voice samples; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `sample_enable`  input  `CHANNELS`: per-voice enable (key held).
- `mix_out`  output  `WIDTH`: last normalised mix.
- `mix_valid`  output  1: one-cycle pulse when `mix_out` updates.
- `busy`  output  1: high while a mix is in progress.
- `overrun`  output  1: one-cycle pulse when `start` arrives while busy.
- `pwm_out`  output  1: registered PWM audio output.

## Operation
- States: IDLE, ACCUM, DIVIDE, DONE.
- IDLE:
  - On `start`, latch `samples` and `sample_enable` into internal registers.
  - Clear the sum (`SUMW` bits), count (`CW` bits) and channel index.
  - Go to ACCUM.
- ACCUM:
  - One channel per cycle, index 0..`CHANNELS-1`.
  - If the latched enable is set, add that sample to the sum and add 1 to the count.
  - After the last index, go to DIVIDE.
- DIVIDE:
  - Restoring division of sum by count, one quotient bit per cycle, MSB first, `SUMW` cycles.
  - The quotient fits in `WIDTH` bits, because the mean never exceeds the maximum sample. Truncate to `WIDTH` bits; the remainder is discarded (floor).
  - Count = 0 (no enabled voices) skips the divide arithmetic and forces quotient = 0, with the same cycle count.
  - Then go to DONE.
- DONE: `mix_out` <= quotient, pulse `mix_valid`, return to IDLE.
- `busy` = 1 in ACCUM, DIVIDE and DONE.
- `start` while busy:
  - It is ignored; the in-flight mix completes using its latched inputs.
  - `overrun` pulses in the cycle after that `start`.
- The latched inputs isolate the computation from input changes mid-mix.
- PWM:
  - Free-running `WIDTH`-bit counter, 0..2^WIDTH-1, wrapping to 0.
  - `duty` register is loaded from `mix_out` only when the counter wraps (counter == all-ones); there are no mid-period glitches.
  - `pwm_out` <= (counter < duty).
  - duty = 0 gives a constant low output.
  - duty = 2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
- Reset (asynchronous, any state, any cycle):
  - State returns to IDLE.
  - All outputs, the PWM counter, `duty` and the internal registers go to 0.
  - Any in-flight mix is abandoned with no `mix_valid`.

## Timing
- `start` sampled high in IDLE at edge k gives `mix_valid` high during the cycle following edge k + 1 + `CHANNELS` + `SUMW`.
- Defaults (12 channels, 8 bits, `SUMW` = 12): `mix_valid` 25 cycles after the `start` edge.
- `busy` rises at edge k and falls at the edge ending DONE.
- A `start` that coincides with the DONE cycle counts as busy: it is ignored and raises `overrun`.
- Minimum legal `start` spacing: `CHANNELS` + `SUMW` + 2 cycles. The 10 MHz clock with a 44.1 kHz strobe gives ample margin.
- Duty update latency:
  - `mix_out` is visible at the next counter wrap, up to 2^WIDTH cycles later.
  - `pwm_out` lags the counter comparison by 1 register cycle.
- Reset outputs: `mix_out`, `mix_valid`, `busy`, `overrun` and `pwm_out` are all 0.

## Test plan
- Reset, then idle 600 cycles -> all outputs 0, `pwm_out` constantly 0, no `mix_valid`.
- Defaults; channels 0, 4, 7 enabled with samples 0x30, 0x60, 0x90; others hold 0xFF, disabled; pulse `start` -> `mix_valid` exactly 25 cycles later with `mix_out` = 0x60; `busy` high for those cycles.
- All 12 channels enabled at 0xFF -> `mix_out` = 0xFF (no overflow, sum 0xBF4). Then samples 1, 2, rest disabled -> `mix_out` = 0x01 (floor).
- `sample_enable` = 0 -> `mix_out` = 0x00 after 25 cycles; `pwm_out` stays low.
- Second `start` 10 cycles after the first, then change `samples` mid-mix -> one `overrun` pulse; a single `mix_valid` with the result from the first-latched inputs.
- `mix_out` = 0x40 loaded -> after the next wrap `pwm_out` is high exactly 64 of 256 cycles per period. Assert `n_rst` low mid-DIVIDE -> immediate IDLE, all outputs 0, no `mix_valid` after release.

Source files
------------

// File: rtl/poly_mix_pwm.sv
// Voice mixer: latches CHANNELS samples on start, averages the enabled ones, drives a PWM pin.
// Latency: mix_valid is high in the cycle after edge k+1+CHANNELS+SUMW, where edge k samples start.
// Backpressure: none; a start while busy is dropped and reported with a one-cycle overrun pulse.
module poly_mix_pwm #(
    parameter int CHANNELS = 12,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic [CHANNELS*WIDTH-1:0] samples,
    input  logic [CHANNELS-1:0]       sample_enable,
    output logic [WIDTH-1:0]          mix_out,
    output logic                      mix_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic                      pwm_out
);

    localparam int SUMW = WIDTH + $clog2(CHANNELS);
    localparam int CW   = $clog2(CHANNELS + 1);
    // One step counter serves both the channel walk and the divide bit count.
    localparam int STW  = $clog2(CHANNELS + SUMW + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]                state;
    logic [CHANNELS*WIDTH-1:0] samples_q;
    logic [CHANNELS-1:0]       enable_q;
    logic [SUMW-1:0]           sum;
    logic [CW-1:0]             count;
    logic [STW-1:0]            step;
    logic [CW-1:0]             rem;
    logic [SUMW-1:0]           quot;

    logic [WIDTH-1:0]          cur_sample;
    logic                      cur_en;
    logic [CW:0]               rem_sh;
    logic [CW:0]               rem_sub;
    logic                      div_ge;

    logic [WIDTH-1:0]          pwm_cnt;
    logic [WIDTH-1:0]          duty;

    assign busy = (state != S_IDLE);

    // Select the latched sample/enable for the channel currently being accumulated.
    always_comb begin
        cur_sample = '0;
        cur_en     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (step == STW'(i)) begin
                cur_sample = samples_q[i*WIDTH +: WIDTH];
                cur_en     = enable_q[i];
            end
        end
    end

    // One restoring-division step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        rem_sh  = {rem, sum[SUMW-1]};
        div_ge  = (rem_sh >= {1'b0, count});
        rem_sub = rem_sh - {1'b0, count};
    end

    // Mix sequencer: latch, accumulate one channel per cycle, divide one bit per cycle, publish.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            samples_q <= '0;
            enable_q  <= '0;
            sum       <= '0;
            count     <= '0;
            step      <= '0;
            rem       <= '0;
            quot      <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            overrun   <= start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        samples_q <= samples;
                        enable_q  <= sample_enable;
                        sum       <= '0;
                        count     <= '0;
                        step      <= '0;
                        rem       <= '0;
                        quot      <= '0;
                        state     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (cur_en) begin
                        sum   <= sum + SUMW'(cur_sample);
                        count <= count + CW'(1);
                    end
                    if (step == STW'(CHANNELS - 1)) begin
                        step  <= '0;
                        state <= S_DIVIDE;
                    end else begin
                        step <= step + STW'(1);
                    end
                end
                S_DIVIDE: begin
                    // With no enabled voices the quotient stays at its cleared zero.
                    if (count != '0) begin
                        rem  <= div_ge ? rem_sub[CW-1:0] : rem_sh[CW-1:0];
                        quot <= (quot << 1) | SUMW'(div_ge);
                        sum  <= sum << 1;
                    end
                    if (step == STW'(SUMW - 1)) begin
                        step  <= '0;
                        state <= S_DONE;
                    end else begin
                        step <= step + STW'(1);
                    end
                end
                default: begin
                    // The mean never exceeds the largest sample, so the low WIDTH bits hold it.
                    mix_out   <= quot[WIDTH-1:0];
                    mix_valid <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // PWM stage: free-running counter, duty refreshed only at wrap so each period is clean.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + WIDTH'(1);
            if (&pwm_cnt) begin
                duty <= mix_out;
            end
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_poly_mix_pwm.sv
// Directed bench for poly_mix_pwm at default parameters (12 voices, 8 bits).
// Table of mix vectors with hand-computed means, plus sequences for overrun and reset.
module tb_poly_mix_pwm;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [95:0] samples = '0;
    logic [11:0] sample_enable = '0;
    logic [7:0]  mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;
    logic        pwm_out;

    int n_checks = 0;
    int n_pass   = 0;

    poly_mix_pwm #(.CHANNELS(12), .WIDTH(8)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .samples(samples),
        .sample_enable(sample_enable),
        .mix_out(mix_out),
        .mix_valid(mix_valid),
        .busy(busy),
        .overrun(overrun),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] en;
        logic [95:0] samp;
        logic [7:0]  exp_mix;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Called at #1 after a posedge; returns latency in cycles, busy-low count before valid, and result.
    task automatic run_mix(input logic [11:0] en, input logic [95:0] s,
                           output int lat, output int busy_bad, output int res);
        sample_enable = en;
        samples       = s;
        start         = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_bad = 0;
        res      = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (mix_valid) begin
                lat = n;
                res = mix_out;
            end else if (!busy) begin
                busy_bad++;
            end
        end
    endtask

    // Let the duty register pick up mix_out, then count high cycles over one full period.
    task automatic pwm_high(output int hi);
        repeat (300) @(posedge clk);
        #1;
        hi = 0;
        repeat (256) begin
            @(posedge clk); #1;
            if (pwm_out) hi++;
        end
    endtask

    initial begin
        int lat, bb, res, hi, bad, ov_cnt, mv_cnt, ov_at, mres, mlat;
        logic [95:0] s;

        // Build the vector table.
        s = {12{8'hFF}}; s[0*8 +: 8] = 8'h30; s[4*8 +: 8] = 8'h60; s[7*8 +: 8] = 8'h90;
        vecs[0] = '{en: 12'h091, samp: s, exp_mix: 8'h60};
        s = {12{8'hFF}};
        vecs[1] = '{en: 12'hFFF, samp: s, exp_mix: 8'hFF};
        s = {12{8'hFF}}; s[0*8 +: 8] = 8'h01; s[1*8 +: 8] = 8'h02;
        vecs[2] = '{en: 12'h003, samp: s, exp_mix: 8'h01};
        s = {12{8'hFF}};
        vecs[3] = '{en: 12'h000, samp: s, exp_mix: 8'h00};
        s = {12{8'hFF}}; s[0*8 +: 8] = 8'h40;
        vecs[4] = '{en: 12'h001, samp: s, exp_mix: 8'h40};
        s = {12{8'h00}}; s[11*8 +: 8] = 8'hAB;
        vecs[5] = '{en: 12'h800, samp: s, exp_mix: 8'hAB};
        s = {12{8'hFF}}; s[3*8 +: 8] = 8'h10; s[5*8 +: 8] = 8'h11;
        vecs[6] = '{en: 12'h028, samp: s, exp_mix: 8'h10};

        // Reset values, then a long idle stretch with everything quiet.
        repeat (3) @(posedge clk);
        #1;
        check("reset_mix_out", mix_out, 0);
        check("reset_mix_valid", mix_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_pwm_out", pwm_out, 0);
        n_rst = 1'b1;
        bad = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (mix_out != 0 || mix_valid || busy || overrun || pwm_out) bad++;
        end
        check("idle_600_quiet_cycles_bad", bad, 0);

        // Table-driven mixes: latency, busy, result, and resulting PWM high time.
        for (int i = 0; i < 7; i++) begin
            run_mix(vecs[i].en, vecs[i].samp, lat, bb, res);
            check($sformatf("vec%0d_latency", i), lat, 25);
            check($sformatf("vec%0d_busy_low", i), bb, 0);
            check($sformatf("vec%0d_mix_out", i), res, vecs[i].exp_mix);
            pwm_high(hi);
            check($sformatf("vec%0d_pwm_high", i), hi, vecs[i].exp_mix);
        end

        // Second start 10 cycles in, with inputs trashed mid-mix.
        sample_enable = vecs[0].en;
        samples       = vecs[0].samp;
        start         = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        ov_cnt = 0; mv_cnt = 0; ov_at = 0; mres = 0; mlat = 0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if (overrun) begin ov_cnt++; if (n == 10) ov_at = 1; end
            if (mix_valid) begin mv_cnt++; mres = mix_out; mlat = n; end
            if (n == 9) begin
                start         = 1'b1;
                samples       = '0;
                sample_enable = 12'hFFF;
            end else begin
                start = 1'b0;
            end
        end
        check("overrun_after_second_start", ov_at, 1);
        check("overrun_pulse_count", ov_cnt, 1);
        check("overrun_mix_valid_count", mv_cnt, 1);
        check("overrun_latency", mlat, 25);
        check("overrun_mix_out", mres, 8'h60);

        // Reset in the middle of the divide phase.
        run_mix(vecs[6].en, vecs[6].samp, lat, bb, res);
        sample_enable = vecs[1].en;
        samples       = vecs[1].samp;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        n_rst = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_mix_out", mix_out, 0);
        check("midreset_pwm_out", pwm_out, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (mix_valid || busy) bad++;
        end
        check("post_reset_no_valid", bad, 0);

        // Block recovers and mixes normally afterwards.
        run_mix(vecs[0].en, vecs[0].samp, lat, bb, res);
        check("recover_latency", lat, 25);
        check("recover_mix_out", res, 8'h60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
